// File: rtl/edge_event_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | edge_event_scheduler                                                     |
// | Per-channel rising-edge capture, serialized by a round-robin arbiter     |
// | onto one valid/ready event port.                                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module edge_event_scheduler #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   level,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   ovf,
  input  logic           ovf_clear
);

  localparam logic [0:0]   c_idle  = 1'b0;
  localparam logic [0:0]   c_offer = 1'b1;
  localparam logic [N-1:0] c_one   = {{(N-1){1'b0}}, 1'b1};

  logic [0:0]     r_state;
  logic [N-1:0]   r_level_q;
  logic [IDW-1:0] r_last_grant;

  logic           w_hs;
  logic [N-1:0]   w_edge;
  logic [N-1:0]   w_hs_mask;
  logic [N-1:0]   w_pending_next;
  logic [N-1:0]   w_ovf_set;
  logic [N-1:0]   w_req;
  logic [IDW-1:0] w_base;
  logic [IDW-1:0] w_sel;
  logic           w_found;
  int             w_idx;

  assign evt_valid      = (r_state == c_offer);
  assign w_hs           = evt_valid & evt_ready;
  assign w_edge         = level & ~r_level_q;
  assign w_hs_mask      = w_hs ? (c_one << evt_id) : '0;
  assign w_pending_next = (pending & ~w_hs_mask) | w_edge;
  assign w_ovf_set      = w_edge & pending & ~w_hs_mask;

  // While offering, search the post-handshake pending set starting after the
  // granted channel; that channel itself is then reached last, so a same-cycle
  // re-pend wins only when nothing else is waiting.
  always_comb begin
    w_req   = (r_state == c_offer) ? w_pending_next : pending;
    w_base  = (r_state == c_offer) ? evt_id : r_last_grant;
    w_sel   = w_base;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = N; k >= 1; k--) begin
      w_idx = (int'(w_base) + k) % N;
      if (w_req[w_idx[IDW-1:0]]) begin
        w_sel   = w_idx[IDW-1:0];
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level_q    <= '1;
      pending      <= '0;
      ovf          <= '0;
      r_state      <= c_idle;
      evt_id       <= '0;
      r_last_grant <= IDW'(N - 1);
    end else begin
      r_level_q <= level;
      pending   <= w_pending_next;
      ovf       <= (ovf & ~{N{ovf_clear}}) | w_ovf_set;
      case (r_state)
        c_idle: begin
          if (w_found) begin
            evt_id  <= w_sel;
            r_state <= c_offer;
          end
        end
        default: begin
          if (w_hs) begin
            r_last_grant <= evt_id;
            if (w_found) begin
              evt_id <= w_sel;
            end else begin
              r_state <= c_idle;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_edge_event_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_edge_event_scheduler                                                  |
// | Directed bench with an expected-event scoreboard for N=4.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_edge_event_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] level;
  logic       evt_ready;
  logic       ovf_clear;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [3:0] pending;
  logic [3:0] ovf;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  edge_event_scheduler #(.N(4), .IDW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .level     (level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .pending   (pending),
    .ovf       (ovf),
    .ovf_clear (ovf_clear)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every accepted event must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      int exp_id;
      exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("event_id", 32'(evt_id), exp_id);
    end
  end

  initial begin
    reset = 1'b1; level = 4'b0000; evt_ready = 1'b0; ovf_clear = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_id", 32'(evt_id), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_ovf", 32'(ovf), 0);
    reset = 1'b0;

    // single event on channel 2
    evt_ready = 1'b1;
    repeat (4) tick();
    level = 4'b0100; exp_q.push_back(2);
    tick();
    chk("single_pending", 32'(pending), 32'b0100);
    chk("single_valid0", 32'(evt_valid), 0);
    tick();
    chk("single_valid1", 32'(evt_valid), 1);
    chk("single_id", 32'(evt_id), 2);
    tick();
    chk("single_valid_end", 32'(evt_valid), 0);
    chk("single_pending_end", 32'(pending), 0);
    level = 4'b0000;
    tick();

    // levels held high through reset release
    level = 4'b1111; reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("supp_valid", 32'(evt_valid), 0);
      chk("supp_pending", 32'(pending), 0);
    end
    level = 4'b0000;
    tick();

    // round-robin over all four channels
    level = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    tick();
    chk("rr_pending", 32'(pending), 32'hf);
    level = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_valid", 32'(evt_valid), 1);
      chk("rr_id", 32'(evt_id), i);
    end
    tick();
    chk("rr_valid_end", 32'(evt_valid), 0);

    // channels 0 and 3 with last_grant=3
    level = 4'b1001; exp_q.push_back(0); exp_q.push_back(3);
    tick();
    level = 4'b0000;
    tick();
    chk("rr2_id_a", 32'(evt_id), 0);
    tick();
    chk("rr2_id_b", 32'(evt_id), 3);
    chk("rr2_valid_b", 32'(evt_valid), 1);
    tick();
    chk("rr2_valid_end", 32'(evt_valid), 0);

    // backpressure and overflow on channel 1
    evt_ready = 1'b0;
    level = 4'b0010; exp_q.push_back(1);
    tick();
    level = 4'b0000;
    tick();
    chk("bp_valid", 32'(evt_valid), 1);
    chk("bp_id", 32'(evt_id), 1);
    tick();
    level = 4'b0010;
    tick();
    level = 4'b0000;
    chk("bp_ovf", 32'(ovf), 32'b0010);
    chk("bp_id_hold", 32'(evt_id), 1);
    chk("bp_valid_hold", 32'(evt_valid), 1);
    tick();
    chk("bp_id_hold2", 32'(evt_id), 1);
    evt_ready = 1'b1;
    tick();
    chk("bp_valid_end", 32'(evt_valid), 0);
    chk("bp_pending_end", 32'(pending), 0);
    chk("bp_ovf_sticky", 32'(ovf), 32'b0010);
    tick();
    chk("bp_single_event", 32'(evt_valid), 0);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("ovf_cleared", 32'(ovf), 0);

    // same-cycle re-pend on channel 1
    evt_ready = 1'b0;
    level = 4'b0010;
    tick();
    level = 4'b0000;
    tick();
    chk("rp_valid", 32'(evt_valid), 1);
    chk("rp_id", 32'(evt_id), 1);
    exp_q.push_back(1); exp_q.push_back(1);
    evt_ready = 1'b1; level = 4'b0010;
    tick();
    level = 4'b0000;
    chk("rp_pending", 32'(pending), 32'b0010);
    chk("rp_ovf", 32'(ovf), 0);
    chk("rp_valid2", 32'(evt_valid), 1);
    chk("rp_id2", 32'(evt_id), 1);
    tick();
    chk("rp_valid_end", 32'(evt_valid), 0);
    chk("rp_pending_end", 32'(pending), 0);

    // asynchronous reset while offering
    evt_ready = 1'b0;
    level = 4'b1010;
    tick();
    level = 4'b0000;
    tick();
    chk("mr_valid", 32'(evt_valid), 1);
    chk("mr_pending", 32'(pending), 32'b1010);
    #2 reset = 1'b1;
    #1;
    chk("mr_async_valid", 32'(evt_valid), 0);
    chk("mr_async_pending", 32'(pending), 0);
    #1 reset = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr_after_valid", 32'(evt_valid), 0);
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_event_scheduler.md
# edge_event_scheduler

Multi-channel rising-edge event scheduler. Each of N synchronous level inputs gets its own rising-edge detector. Detected edges are latched as pending events, and a round-robin arbiter serializes them onto one valid/ready event port carrying the channel index. It sits between the debounced/synchronized button and switch levels and the single downstream command consumer that services one event at a time.

## Interface
- N, default 4: number of level channels, 2..16.
- IDW, default $clog2(N): width of evt_id.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high; clock clk.
- level  input  N  per-channel level; synchronous to clk (synchronizers upstream).
- evt_valid  output  1  event offered on evt_id.
- evt_ready  input  1  consumer accepts the event when high together with evt_valid.
- evt_id  output  IDW  channel index of the offered event.
- pending  output  N  per-channel pending-event flags, registered.
- ovf  output  N  sticky per-channel overflow flags.
- ovf_clear  input  1  single-cycle pulse that clears all ovf bits.

## Operation
- Edge detection per channel:
  - level_q[i] samples level[i] every cycle.
  - edge[i] = level[i] & ~level_q[i].
  - level_q resets to all ones, so a level held high through reset release never produces an event.
- Pending latch:
  - edge[i] sets pending[i].
  - A handshake on channel i clears pending[i], unless edge[i] occurs in the same cycle; then pending[i] stays set and ovf is not set.
- Overflow:
  - edge[i] while pending[i] is set and channel i is not being handshaken that cycle sets ovf[i].
  - The event is merged, not queued.
  - ovf_clear clears all bits. If a set and a clear land in the same cycle, set wins.
- Arbiter FSM, 2 states:
  - IDLE: evt_valid=0. If pending != 0, select a channel (rule below), register it into evt_id, and go to OFFER.
  - OFFER: evt_valid=1, and evt_id is held stable until the handshake.
  - On handshake in OFFER: last_grant <= evt_id. If any other pending bit is set, or the same channel re-pends via a same-cycle edge, select the next channel and stay in OFFER (back-to-back). Otherwise go to IDLE.
- Selection is round-robin: the first pending channel searching from (last_grant+1) mod N upward, with wrap.
  - The bit being cleared this cycle is excluded.
  - A same-cycle edge on that channel is included, at lowest priority.
- last_grant resets to N-1, so channel 0 has top priority after reset.
- evt_id is never changed while evt_valid=1 and evt_ready=0.
- Edges arriving while in OFFER only update pending; they never preempt the offered event.

## Timing
- Reset values: evt_valid=0, evt_id=0, pending=0, ovf=0, FSM=IDLE, level_q=all ones.
- Asynchronous reset mid-offer drops all pending events and deasserts evt_valid immediately.
- Latency: level[i] rises before edge k, so pending[i]=1 after edge k and evt_valid=1 with evt_id=i after edge k+1. Minimum latency is 2 cycles.
- Throughput: one event per cycle when evt_ready is held high and several channels are pending.
- Each event is visible for at least 1 cycle. A level pulse of 1 cycle is still captured.
- pending and ovf are pure registers; evt_valid and evt_id are registered. There are no combinational paths from inputs to outputs.

## Test plan (N=4)
- Single event:
  - Stimulus: after reset, raise level[2] at cycle 5, with evt_ready=1.
  - Response: pending=0100 after edge 5; evt_valid=1 and evt_id=2 after edge 6, for exactly 1 cycle; pending=0000 after the handshake.
- Reset suppression:
  - Stimulus: level=1111 held through reset release, then unchanged.
  - Response: evt_valid stays 0 and pending stays 0000 for 20 cycles.
- Round-robin:
  - Stimulus: raise level[3:0]=1111 in the same cycle, with evt_ready=1.
  - Response: evt_id sequence 0,1,2,3 on consecutive cycles with evt_valid continuously high, then evt_valid=0.
  - Stimulus: afterwards, pulse channels 0 and 3 together.
  - Response: order 0 then 3, because last_grant=3.
- Backpressure and overflow:
  - Stimulus: evt_ready=0; pulse level[1] twice, 3 cycles apart.
  - Response: evt_id=1 held stable with evt_valid=1; ovf=0010 after the second edge; raising evt_ready yields exactly one event on channel 1.
  - Stimulus: ovf_clear pulse.
  - Response: ovf=0000.
- Same-cycle re-pend:
  - Stimulus: channel 1 is being handshaken while a new edge[1] occurs in that cycle.
  - Response: pending[1] stays 1, ovf[1] stays 0, and a second channel-1 event follows on the next cycle.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously while evt_valid=1 and pending=1010.
  - Response: evt_valid=0 and pending=0000 immediately, with no clock edge required; after release, no events until new rising edges occur.
